// File: rtl/uncache_wbuf.sv
// uncache_wbuf: uncached-access unit between the CPU memory stage and the
// AXI bridge request port.
//
// Writes are posted into a DEPTH-entry in-order buffer and stall the CPU only
// when that buffer is full. Reads stall until every earlier buffered write
// has drained and the read data has returned. Only one bus transaction is
// outstanding at a time, so reads and writes reach the bus in program order.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   conf_en              CPU access request (held while stallreq=1)
//   conf_wen             byte write enables, 0 = read
//   conf_addr/conf_wdata access address / write data
//   conf_rdata           registered read data
//   stallreq             combinational pipeline stall
//   wbuf_empty           no buffered or in-flight write (for fence/sync)
//   axi_en/axi_wsel/axi_addr/axi_wdata  registered bus request, wsel 0 = read
//   reload               one-cycle completion pulse of the bus transaction
//   axi_rdata            read data, valid with reload

module uncache_wbuf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conf_en,
  input  logic [STRB_W-1:0] conf_wen,
  input  logic [ADDR_W-1:0] conf_addr,
  input  logic [DATA_W-1:0] conf_wdata,
  output logic [DATA_W-1:0] conf_rdata,
  output logic              stallreq,
  output logic              wbuf_empty,
  output logic              axi_en,
  output logic [STRB_W-1:0] axi_wsel,
  output logic [ADDR_W-1:0] axi_addr,
  output logic [DATA_W-1:0] axi_wdata,
  input  logic              reload,
  input  logic [DATA_W-1:0] axi_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RDONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0] buf_addr_q  [DEPTH];
  logic [STRB_W-1:0] buf_wen_q   [DEPTH];
  logic [DATA_W-1:0] buf_wdata_q [DEPTH];

  logic [DATA_W-1:0] conf_rdata_q, conf_rdata_d;
  logic              axi_en_q, axi_en_d;
  logic [STRB_W-1:0] axi_wsel_q, axi_wsel_d;
  logic [ADDR_W-1:0] axi_addr_q, axi_addr_d;
  logic [DATA_W-1:0] axi_wdata_q, axi_wdata_d;

  logic rdone;
  logic wr_req;
  logic rd_req;
  logic full;
  logic push;
  logic pop;

  // rdone masks the still-held CPU request for the single cycle after a read
  // completes, so the same read is not issued twice.
  assign rdone  = (state_q == RDONE);
  assign wr_req = conf_en & (|conf_wen) & ~rdone;
  assign rd_req = conf_en & ~(|conf_wen) & ~rdone;
  assign full   = (count_q == FULL_CNT);

  // Push is decided on the registered count only: a pop in the same cycle
  // does not free a slot until the next cycle.
  assign push = wr_req & ~full;
  assign pop  = (state_q == WR) & reload;

  assign stallreq   = (wr_req & full) | rd_req;
  assign wbuf_empty = (count_q == '0) & (state_q != WR);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Buffer storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[wr_ptr_q]  <= conf_addr;
      buf_wen_q[wr_ptr_q]   <= conf_wen;
      buf_wdata_q[wr_ptr_q] <= conf_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    conf_rdata_d = conf_rdata_q;
    axi_en_d     = axi_en_q;
    axi_wsel_d   = axi_wsel_q;
    axi_addr_d   = axi_addr_q;
    axi_wdata_d  = axi_wdata_q;
    case (state_q)
      IDLE: begin
        // Buffered writes always go ahead of a pending read.
        if (count_q != '0) begin
          axi_en_d    = 1'b1;
          axi_wsel_d  = buf_wen_q[rd_ptr_q];
          axi_addr_d  = buf_addr_q[rd_ptr_q];
          axi_wdata_d = buf_wdata_q[rd_ptr_q];
          state_d     = WR;
        end else if (rd_req) begin
          axi_en_d    = 1'b1;
          axi_wsel_d  = '0;
          axi_addr_d  = conf_addr;
          axi_wdata_d = conf_wdata;
          state_d     = RD;
        end
      end
      WR: begin
        if (reload) begin
          axi_en_d    = 1'b0;
          axi_wsel_d  = '0;
          axi_addr_d  = '0;
          axi_wdata_d = '0;
          state_d     = IDLE;
        end
      end
      RD: begin
        if (reload) begin
          conf_rdata_d = axi_rdata;
          axi_en_d     = 1'b0;
          axi_wsel_d   = '0;
          axi_addr_d   = '0;
          axi_wdata_d  = '0;
          state_d      = RDONE;
        end
      end
      RDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      conf_rdata_q <= '0;
      axi_en_q     <= 1'b0;
      axi_wsel_q   <= '0;
      axi_addr_q   <= '0;
      axi_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      conf_rdata_q <= conf_rdata_d;
      axi_en_q     <= axi_en_d;
      axi_wsel_q   <= axi_wsel_d;
      axi_addr_q   <= axi_addr_d;
      axi_wdata_q  <= axi_wdata_d;
    end
  end

  assign conf_rdata = conf_rdata_q;
  assign axi_en     = axi_en_q;
  assign axi_wsel   = axi_wsel_q;
  assign axi_addr   = axi_addr_q;
  assign axi_wdata  = axi_wdata_q;

endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed testbench for uncache_wbuf (DATA_W=64, DEPTH=4).

module tb_uncache_wbuf;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk;
  logic          reset;
  logic          conf_en;
  logic [SW-1:0] conf_wen;
  logic [AW-1:0] conf_addr;
  logic [DW-1:0] conf_wdata;
  logic [DW-1:0] conf_rdata;
  logic          stallreq;
  logic          wbuf_empty;
  logic          axi_en;
  logic [SW-1:0] axi_wsel;
  logic [AW-1:0] axi_addr;
  logic [DW-1:0] axi_wdata;
  logic          reload;
  logic [DW-1:0] axi_rdata;

  int unsigned n_vec;
  int unsigned n_err;

  uncache_wbuf #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STRB_W(SW),
    .DEPTH (4),
    .CNT_W (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .conf_en   (conf_en),
    .conf_wen  (conf_wen),
    .conf_addr (conf_addr),
    .conf_wdata(conf_wdata),
    .conf_rdata(conf_rdata),
    .stallreq  (stallreq),
    .wbuf_empty(wbuf_empty),
    .axi_en    (axi_en),
    .axi_wsel  (axi_wsel),
    .axi_addr  (axi_addr),
    .axi_wdata (axi_wdata),
    .reload    (reload),
    .axi_rdata (axi_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic en, input logic [SW-1:0] wen,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    conf_en    = en;
    conf_wen   = wen;
    conf_addr  = addr;
    conf_wdata = wdata;
  endtask

  // Wait (bounded) for a bus request, check it, check it holds for a cycle,
  // then complete it with a reload pulse. Returns in the cycle after reload.
  task automatic serve(input string tag, input logic [AW-1:0] a, input logic [SW-1:0] ws,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    int unsigned n;
    n = 0;
    while (!axi_en && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_en"},    64'(axi_en),    64'd1);
    check({tag, "_addr"},  64'(axi_addr),  64'(a));
    check({tag, "_wsel"},  64'(axi_wsel),  64'(ws));
    check({tag, "_wdata"}, 64'(axi_wdata), 64'(wd));
    tick();
    check({tag, "_hold"},  64'({axi_en, axi_addr}), 64'({1'b1, a}));
    reload    = 1'b1;
    axi_rdata = rd;
    tick();
    reload    = 1'b0;
    axi_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    reload    = 1'b0;
    axi_rdata = '0;
    drive(1'b0, '0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_axi_en",     64'(axi_en),     64'd0);
    check("rst_axi_wsel",   64'(axi_wsel),   64'd0);
    check("rst_axi_addr",   64'(axi_addr),   64'd0);
    check("rst_axi_wdata",  64'(axi_wdata),  64'd0);
    check("rst_conf_rdata", 64'(conf_rdata), 64'd0);
    check("rst_wbuf_empty", 64'(wbuf_empty), 64'd1);
    check("rst_stallreq",   64'(stallreq),   64'd0);
    reset = 1'b0;

    // Single read, reload at cycle 4
    tick();
    drive(1'b1, '0, 32'h1faf_fff0, '0);
    #1;
    check("rd_c0_stall", 64'(stallreq), 64'd1);
    check("rd_c0_en",    64'(axi_en),   64'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        reload    = 1'b1;
        axi_rdata = 64'h1234_5678;
      end
      check("rd_bus", 64'({axi_en, axi_wsel, axi_addr, stallreq}),
            64'({1'b1, 8'h00, 32'h1faf_fff0, 1'b1}));
    end
    tick();
    reload    = 1'b0;
    axi_rdata = '0;
    #1;
    check("rd_c5_rdata", 64'(conf_rdata), 64'h1234_5678);
    check("rd_c5_stall", 64'(stallreq),   64'd0);
    check("rd_c5_en",    64'(axi_en),     64'd0);
    drive(1'b0, '0, '0, '0);
    tick();

    // Three posted writes
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hFF, 32'h0000_1000 + 32'(i * 4), 64'hD000_0000 + 64'(i));
      #1;
      check("pw_stall", 64'(stallreq), 64'd0);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    check("pw_not_empty0", 64'(wbuf_empty), 64'd0);
    serve("pw0", 32'h0000_1000, 8'hFF, 64'hD000_0000, '0);
    check("pw_not_empty1", 64'(wbuf_empty), 64'd0);
    serve("pw1", 32'h0000_1004, 8'hFF, 64'hD000_0001, '0);
    check("pw_not_empty2", 64'(wbuf_empty), 64'd0);
    serve("pw2", 32'h0000_1008, 8'hFF, 64'hD000_0002, '0);
    check("pw_empty", 64'(wbuf_empty), 64'd1);
    tick();

    // Buffer full: 5 writes, reload held low
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hFF, 32'h0000_2000 + 32'(i * 4), 64'hE000_0000 + 64'(i));
      #1;
      check("full_push_stall", 64'(stallreq), 64'd0);
      tick();
    end
    drive(1'b1, 8'hFF, 32'h0000_2010, 64'hE000_0004);
    #1;
    check("full_c4_stall", 64'(stallreq), 64'd1);
    tick();
    check("full_c5_stall", 64'(stallreq), 64'd1);
    check("full_c5_bus",   64'({axi_en, axi_addr}), 64'({1'b1, 32'h0000_2000}));
    reload = 1'b1;
    tick();
    reload = 1'b0;
    #1;
    check("full_c6_stall", 64'(stallreq), 64'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    serve("full1", 32'h0000_2004, 8'hFF, 64'hE000_0001, '0);
    serve("full2", 32'h0000_2008, 8'hFF, 64'hE000_0002, '0);
    serve("full3", 32'h0000_200C, 8'hFF, 64'hE000_0003, '0);
    check("full_not_empty", 64'(wbuf_empty), 64'd0);
    serve("full4", 32'h0000_2010, 8'hFF, 64'hE000_0004, '0);
    check("full_empty", 64'(wbuf_empty), 64'd1);
    tick();
    check("full_no_extra", 64'(axi_en), 64'd0);

    // Read after two writes
    drive(1'b1, 8'hFF, 32'h0000_3000, 64'h0000_0000_B0B0_B0B0);
    tick();
    drive(1'b1, 8'hFF, 32'h0000_3004, 64'h0000_0000_B1B1_B1B1);
    tick();
    drive(1'b1, '0, 32'h0000_3000, '0);
    #1;
    check("raw_stall0", 64'(stallreq), 64'd1);
    serve("raw_w0", 32'h0000_3000, 8'hFF, 64'h0000_0000_B0B0_B0B0, '0);
    check("raw_stall1", 64'(stallreq), 64'd1);
    serve("raw_w1", 32'h0000_3004, 8'hFF, 64'h0000_0000_B1B1_B1B1, '0);
    check("raw_stall2", 64'(stallreq), 64'd1);
    check("raw_empty",  64'(wbuf_empty), 64'd1);
    serve("raw_rd", 32'h0000_3000, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF);
    #1;
    check("raw_rdata", 64'(conf_rdata), 64'h0123_4567_89AB_CDEF);
    check("raw_stall3", 64'(stallreq), 64'd0);
    drive(1'b0, '0, '0, '0);
    tick();

    // Partial byte enables on the 64-bit bus
    drive(1'b1, 8'h0F, 32'h0000_4000, 64'hAABB_CCDD_1122_3344);
    #1;
    check("be_stall", 64'(stallreq), 64'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    serve("be", 32'h0000_4000, 8'h0F, 64'hAABB_CCDD_1122_3344, '0);
    tick();

    // Asynchronous reset in the middle of a read
    drive(1'b1, '0, 32'h0000_5000, '0);
    tick();
    check("ar_en_before", 64'(axi_en), 64'd1);
    reset = 1'b1;
    drive(1'b0, '0, '0, '0);
    #1;
    check("ar_axi", 64'({axi_en, axi_wsel, axi_addr}), 64'd0);
    check("ar_axi_wdata",  64'(axi_wdata),  64'd0);
    check("ar_conf_rdata", 64'(conf_rdata), 64'd0);
    check("ar_empty",      64'(wbuf_empty), 64'd1);
    check("ar_stall",      64'(stallreq),   64'd0);
    #2;
    reset = 1'b0;
    tick();
    reload    = 1'b1;
    axi_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    reload    = 1'b0;
    axi_rdata = '0;
    check("ar_ign_rdata", 64'(conf_rdata), 64'd0);
    check("ar_ign_en",    64'(axi_en),     64'd0);
    drive(1'b1, '0, 32'h0000_6000, '0);
    serve("ar_rd", 32'h0000_6000, 8'h00, 64'd0, 64'h5555_AAAA_0000_FFFF);
    #1;
    check("ar_rdata", 64'(conf_rdata), 64'h5555_AAAA_0000_FFFF);
    check("ar_stall_done", 64'(stallreq), 64'd0);
    drive(1'b0, '0, '0, '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
